// File: rtl/sram_arbiter_2x1.sv
// rtl/sram_arbiter_2x1.sv - two-master sram bus arbiter, data-first with inst anti-starvation
// Owner FIFO routes in-order data_ok/rdata back to the master that issued each request.
module sram_arbiter_2x1 #(
    parameter int DEPTH      = 4,
    parameter int STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        ram_req,
    output logic        ram_wr,
    output logic [1:0]  ram_size,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_addr_ok,
    input  logic        ram_data_ok
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

    typedef enum logic [1:0] {UNLOCKED, LOCK_INST, LOCK_DATA} lock_e;
    typedef enum logic [1:0] {SEL_NONE, SEL_INST, SEL_DATA} sel_e;

    lock_e            lock_q, lock_d;
    sel_e             sel;
    logic [DEPTH-1:0] owner_q, owner_d;
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [SW-1:0]    streak_q, streak_d;
    logic             sel_req, hs, pop, head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q   <= UNLOCKED;
            owner_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            streak_q <= '0;
        end else begin
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        sel = SEL_NONE;
        case (lock_q)
            LOCK_INST: sel = SEL_INST;
            LOCK_DATA: sel = SEL_DATA;
            default: begin
                if (inst_req && streak_q == STREAK_LIM) sel = SEL_INST;
                else if (data_req)                      sel = SEL_DATA;
                else if (inst_req)                      sel = SEL_INST;
            end
        endcase
    end

    always_comb begin
        sel_req   = 1'b0;
        ram_wr    = 1'b0;
        ram_size  = 2'b00;
        ram_addr  = '0;
        ram_wdata = '0;
        case (sel)
            SEL_INST: begin
                sel_req   = inst_req;
                ram_wr    = inst_wr;
                ram_size  = inst_size;
                ram_addr  = inst_addr;
                ram_wdata = inst_wdata;
            end
            SEL_DATA: begin
                sel_req   = data_req;
                ram_wr    = data_wr;
                ram_size  = data_size;
                ram_addr  = data_addr;
                ram_wdata = data_wdata;
            end
            default: ;
        endcase
    end

    // Full blocks the request even when a pop lands in the same cycle.
    assign ram_req      = sel_req & (count_q != FULL_CNT) & ~rst;
    assign hs           = ram_req & ram_addr_ok;
    assign inst_addr_ok = hs & (sel == SEL_INST);
    assign data_addr_ok = hs & (sel == SEL_DATA);

    assign pop          = ram_data_ok & (count_q != '0) & ~rst;
    assign head         = owner_q[rptr_q];
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = ram_rdata;
    assign data_rdata   = ram_rdata;

    always_comb begin
        lock_d   = lock_q;
        owner_d  = owner_q;
        wptr_d   = wptr_q + AW'(hs);
        rptr_d   = rptr_q + AW'(pop);
        count_d  = count_q + (AW + 1)'(hs) - (AW + 1)'(pop);
        streak_d = streak_q;
        if (hs) begin
            lock_d          = UNLOCKED;
            owner_d[wptr_q] = (sel == SEL_DATA);
        end else if (ram_req) begin
            lock_d = (sel == SEL_DATA) ? LOCK_DATA : LOCK_INST;
        end
        if (!inst_req)
            streak_d = '0;
        else if (hs && sel == SEL_INST)
            streak_d = '0;
        else if (hs && sel == SEL_DATA && streak_q < STREAK_LIM)
            streak_d = streak_q + 1'b1;
    end
endmodule
